// File: rtl/adc_trig_pkg.sv
// rtl/adc_trig_pkg.sv - shared state, edge and width definitions for the ADC trigger detector
package adc_trig_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        HOLDOFF = 2'd1,
        ARMED   = 2'd2,
        READY   = 2'd3
    } trig_state_e;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

endpackage

// File: rtl/adc_trig_if.sv
// rtl/adc_trig_if.sv - sample stream, configuration and trigger status bundle
interface adc_trig_if #(
    parameter int DW = 14,
    parameter int HW = 32,
    parameter int CW = 32
);
    import adc_trig_pkg::*;

    logic signed [DW-1:0]      adc_dat_i;
    logic                      adc_dv_i;
    logic signed [DW-1:0]      cfg_lvl_i;
    logic        [DW-1:0]      cfg_hyst_i;
    logic                      cfg_edge_i;
    logic        [HW-1:0]      cfg_holdoff_i;
    logic                      arm_i;
    logic                      disarm_i;
    logic                      trig_o;
    logic                      armed_o;
    logic        [STATE_W-1:0] state_o;
    logic        [CW-1:0]      trig_cnt_o;

    modport master (
        output adc_dat_i, adc_dv_i, cfg_lvl_i, cfg_hyst_i, cfg_edge_i,
               cfg_holdoff_i, arm_i, disarm_i,
        input  trig_o, armed_o, state_o, trig_cnt_o
    );

    modport slave (
        input  adc_dat_i, adc_dv_i, cfg_lvl_i, cfg_hyst_i, cfg_edge_i,
               cfg_holdoff_i, arm_i, disarm_i,
        output trig_o, armed_o, state_o, trig_cnt_o
    );
endinterface

// File: rtl/adc_trig_cmp.sv
// rtl/adc_trig_cmp.sv - combinational precondition/fire comparator on widened signed arithmetic
module adc_trig_cmp
    import adc_trig_pkg::*;
#(
    parameter int DW = 14
) (
    input  logic signed [DW-1:0] sample_i,
    input  logic signed [DW-1:0] lvl_i,
    input  logic        [DW-1:0] hyst_i,
    input  logic                 edge_i,
    output logic                 pre_ok_o,
    output logic                 fire_ok_o
);

    // Two extra bits cover lvl +/- hyst for any input without wrap.
    logic signed [DW+1:0] smp_w;
    logic signed [DW+1:0] lvl_w;
    logic signed [DW+1:0] hyst_w;
    logic signed [DW+1:0] thr_lo;
    logic signed [DW+1:0] thr_hi;

    assign smp_w  = {{2{sample_i[DW-1]}}, sample_i};
    assign lvl_w  = {{2{lvl_i[DW-1]}}, lvl_i};
    assign hyst_w = {2'b00, hyst_i};
    assign thr_lo = lvl_w - hyst_w;
    assign thr_hi = lvl_w + hyst_w;

    // Rising needs the signal clearly below the band first, falling clearly above.
    always_comb begin
        pre_ok_o  = 1'b0;
        fire_ok_o = 1'b0;
        if (edge_i == EDGE_FALL) begin
            pre_ok_o  = smp_w > thr_hi;
            fire_ok_o = smp_w <= lvl_w;
        end else begin
            pre_ok_o  = smp_w < thr_lo;
            fire_ok_o = smp_w >= lvl_w;
        end
    end

endmodule

// File: rtl/adc_trig_detect.sv
// rtl/adc_trig_detect.sv - single-shot edge trigger FSM; HOLDOFF state present only with TRIG_HOLDOFF_EN
module adc_trig_detect
    import adc_trig_pkg::*;
#(
    parameter int DW = 14,
    parameter int HW = 32,
    parameter int CW = 32
) (
    input  logic        adc_clk_i,
    input  logic        adc_rstn_i,
    adc_trig_if.slave   bus
);

    trig_state_e   state_q, state_d;
    logic          trig_q, trig_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pre_ok;
    logic          fire_ok;
`ifdef TRIG_HOLDOFF_EN
    logic [HW-1:0] hold_q, hold_d;
`endif

    adc_trig_cmp #(.DW(DW)) u_cmp (
        .sample_i  (bus.adc_dat_i),
        .lvl_i     (bus.cfg_lvl_i),
        .hyst_i    (bus.cfg_hyst_i),
        .edge_i    (bus.cfg_edge_i),
        .pre_ok_o  (pre_ok),
        .fire_ok_o (fire_ok)
    );

    // Next-state logic; disarm overrides arming and a firing sample alike.
    always_comb begin
        state_d = state_q;
        trig_d  = 1'b0;
        cnt_d   = cnt_q;
`ifdef TRIG_HOLDOFF_EN
        hold_d  = hold_q;
`endif
        if (bus.disarm_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.arm_i) begin
`ifdef TRIG_HOLDOFF_EN
                        if (bus.cfg_holdoff_i == '0) begin
                            state_d = ARMED;
                        end else begin
                            state_d = HOLDOFF;
                            hold_d  = bus.cfg_holdoff_i;
                        end
`else
                        state_d = ARMED;
`endif
                    end
                end
                HOLDOFF: begin
`ifdef TRIG_HOLDOFF_EN
                    if (bus.adc_dv_i) begin
                        hold_d = hold_q - 1'b1;
                        if (hold_q == HW'(1)) begin
                            state_d = ARMED;
                        end
                    end
`else
                    state_d = IDLE;
`endif
                end
                ARMED: begin
                    if (bus.adc_dv_i && pre_ok) begin
                        state_d = READY;
                    end
                end
                READY: begin
                    if (bus.adc_dv_i && fire_ok) begin
                        trig_d  = 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, pulse and counter registers.
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            state_q <= IDLE;
            trig_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef TRIG_HOLDOFF_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            trig_q  <= trig_d;
            cnt_q   <= cnt_d;
`ifdef TRIG_HOLDOFF_EN
            hold_q  <= hold_d;
`endif
        end
    end

    assign bus.trig_o     = trig_q;
    assign bus.trig_cnt_o = cnt_q;
    assign bus.state_o    = state_q;
    assign bus.armed_o    = (state_q != IDLE);

endmodule
